// File: rtl/prod_acc.sv
// prod_acc: sums N_TERMS 4-bit products per block and hands the result downstream.
// Build option: define PROD_ACC_SAT_EN to saturate acc instead of wrapping.
module prod_acc #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [3:0]       product,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] sum,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = $clog2(N_TERMS + 1);
    localparam logic [CW-1:0] LAST = CW'(N_TERMS - 1);
    localparam logic [ACC_W-1:0] MAX = '1;

    typedef enum logic {
        S_ACC,
        S_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             accept;
    logic             last;
    logic [ACC_W:0]   add;

    // Handshake qualifiers and the widened add that exposes the carry
    always_comb begin
        accept = in_valid && (state_q == S_ACC);
        last   = (cnt_q == LAST);
        add    = {1'b0, acc_q} + {{(ACC_W - 3){1'b0}}, product};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: final accept enters HOLD, downstream take returns to ACC
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_ACC;
        end else begin
            case (state_q)
                S_ACC:  if (accept && last) state_d = S_HOLD;
                S_HOLD: if (out_ready) state_d = S_ACC;
                default: state_d = S_ACC;
            endcase
        end
    end

    // Outputs: handshake from state, result straight from the accumulator
    always_comb begin
        in_ready  = (state_q == S_ACC);
        out_valid = (state_q == S_HOLD);
        sum       = acc_q;
        ovf       = ovf_q;
    end

    // Datapath next values; clear and block restart both zero the block
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear || ((state_q == S_HOLD) && out_ready)) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
            ovf_d = ovf_q | add[ACC_W];
`ifdef PROD_ACC_SAT_EN
            acc_d = add[ACC_W] ? MAX : add[ACC_W-1:0];
`else
            acc_d = add[ACC_W-1:0];
`endif
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_prod_acc.sv
// tb_prod_acc: three prod_acc configurations share one stimulus stream and
// are checked every cycle against a block-sum model, plus literal pins.
module tb_prod_acc;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic [3:0] product;
    logic       in_valid;
    logic       out_ready;

    logic       ir0, ir5, ir1;
    logic       ov0, ov5, ov1;
    logic       of0, of5, of1;
    logic [7:0] sum0, sum1;
    logic [4:0] sum5;

    int n_pass = 0;
    int n_total = 0;

    prod_acc #(.N_TERMS(4), .ACC_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .product(product),
        .in_valid(in_valid), .in_ready(ir0), .sum(sum0), .ovf(of0),
        .out_valid(ov0), .out_ready(out_ready)
    );

    prod_acc #(.N_TERMS(4), .ACC_W(5)) u5 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .product(product),
        .in_valid(in_valid), .in_ready(ir5), .sum(sum5), .ovf(of5),
        .out_valid(ov5), .out_ready(out_ready)
    );

    prod_acc #(.N_TERMS(1), .ACC_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .product(product),
        .in_valid(in_valid), .in_ready(ir1), .sum(sum1), .ovf(of1),
        .out_valid(ov1), .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: per instance, holding flag, terms taken, exact unbounded total
    int nt[3] = '{4, 4, 1};
    int wd[3] = '{8, 5, 8};
    bit m_hold[3] = '{0, 0, 0};
    int m_cnt[3] = '{0, 0, 0};
    int m_tot[3] = '{0, 0, 0};

    function automatic int exp_sum(int i);
        int mx;
        mx = (1 << wd[i]) - 1;
`ifdef PROD_ACC_SAT_EN
        return (m_tot[i] > mx) ? mx : m_tot[i];
`else
        return m_tot[i] % (mx + 1);
`endif
    endfunction

    function automatic int exp_ovf(int i);
        return (m_tot[i] > (1 << wd[i]) - 1) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_hold[i] = 0;
            m_cnt[i] = 0;
            m_tot[i] = 0;
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n || clear) begin
            model_reset();
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (m_hold[i]) begin
                    if (out_ready) begin
                        m_hold[i] = 0;
                        m_cnt[i] = 0;
                        m_tot[i] = 0;
                    end
                end else if (in_valid) begin
                    m_tot[i] += int'(product);
                    m_cnt[i]++;
                    if (m_cnt[i] == nt[i]) m_hold[i] = 1;
                end
            end
        end
    end

    task automatic chk(string nm, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Per-cycle compare of all three instances against the model
    always @(negedge clk) begin
        int s[3];
        int v[3];
        int r[3];
        int o[3];
        s = '{int'(sum0), int'(sum5), int'(sum1)};
        v = '{int'(ov0), int'(ov5), int'(ov1)};
        r = '{int'(ir0), int'(ir5), int'(ir1)};
        o = '{int'(of0), int'(of5), int'(of1)};
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d out_valid", i), v[i], int'(m_hold[i]));
            chk($sformatf("u%0d in_ready", i), r[i], int'(!m_hold[i]));
            if (m_hold[i]) begin
                chk($sformatf("u%0d sum", i), s[i], exp_sum(i));
                chk($sformatf("u%0d ovf", i), o[i], exp_ovf(i));
            end
        end
    end

    task automatic cyc(bit c, bit v, int p, bit r);
        clear = c;
        in_valid = v;
        product = 4'(p);
        out_ready = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic blk(int a, int b, int c, int d, bit r);
        cyc(0, 1, a, r);
        cyc(0, 1, b, r);
        cyc(0, 1, c, r);
        cyc(0, 1, d, r);
    endtask

    task automatic pin_zero(string tag);
        chk({tag, " u0 sum"}, sum0, 0);
        chk({tag, " u0 ovf"}, of0, 0);
        chk({tag, " u0 out_valid"}, ov0, 0);
        chk({tag, " u0 in_ready"}, ir0, 1);
        chk({tag, " u5 sum"}, sum5, 0);
        chk({tag, " u1 out_valid"}, ov1, 0);
    endtask

    task automatic rst_pulse(string tag);
        clear = 0;
        in_valid = 0;
        #2 rst_n = 0;
        model_reset();
        #1 pin_zero(tag);
        @(negedge clk);
        #2 rst_n = 1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 0;
        clear = 0;
        product = 0;
        in_valid = 0;
        out_ready = 0;
        repeat (2) @(negedge clk);
        pin_zero("reset");
        #2 rst_n = 1;
        @(negedge clk);

        // 1,4,9,0 back to back
        cyc(1, 0, 0, 1);
        blk(1, 4, 9, 0, 1);
        chk("r26 out_valid", ov0, 1);
        chk("r26 sum", sum0, 14);
        chk("r26 ovf", of0, 0);
        cyc(0, 0, 0, 1);
        chk("r26 out_valid drop", ov0, 0);

        // Backpressure hold
        blk(2, 2, 2, 2, 0);
        for (int k = 0; k < 5; k++) begin
            chk("r27 hold sum", sum0, 8);
            chk("r27 hold in_ready", ir0, 0);
            cyc(0, 1, 2, 0);
        end
        cyc(0, 1, 2, 1);
        chk("r27 release", ov0, 0);
        blk(1, 1, 1, 1, 1);
        chk("r27 next sum", sum0, 4);
        cyc(0, 0, 0, 1);

        // Overflow on the narrow instance
        blk(9, 9, 9, 9, 1);
`ifdef PROD_ACC_SAT_EN
        chk("r28 w5 sum", sum5, 31);
`else
        chk("r28 w5 sum", sum5, 4);
`endif
        chk("r28 w5 ovf", of5, 1);
        chk("r28 w8 sum", sum0, 36);
        chk("r28 w8 ovf", of0, 0);
        cyc(0, 0, 0, 1);
        blk(1, 1, 1, 1, 1);
        chk("r28 w5 next sum", sum5, 4);
        chk("r28 w5 next ovf", of5, 0);
        cyc(0, 0, 0, 1);

        // Clear mid-block discards its product
        cyc(0, 1, 3, 1);
        cyc(0, 1, 3, 1);
        cyc(1, 1, 9, 1);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 1, 1);
            chk("r29 early valid", ov0, 0);
        end
        cyc(0, 1, 1, 1);
        chk("r29 valid", ov0, 1);
        chk("r29 sum", sum0, 4);
        cyc(0, 0, 0, 1);

        // Async reset mid-block and in HOLD
        cyc(0, 1, 5, 1);
        cyc(0, 1, 6, 1);
        rst_pulse("r30 mid");
        blk(2, 3, 4, 5, 1);
        chk("r30 sum a", sum0, 14);
        cyc(0, 0, 0, 1);
        blk(7, 7, 7, 7, 0);
        chk("r30 hold", ov0, 1);
        chk("r30 hold sum", sum0, 28);
        rst_pulse("r30 hold");
        blk(1, 2, 3, 4, 1);
        chk("r30 sum b", sum0, 10);
        cyc(0, 0, 0, 1);

        // Single-term blocks
        cyc(1, 0, 0, 1);
        cyc(0, 1, 9, 1);
        chk("r31 valid a", ov1, 1);
        chk("r31 sum a", sum1, 9);
        cyc(0, 0, 0, 1);
        chk("r31 drop", ov1, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 4, 1);
        chk("r31 valid b", ov1, 1);
        chk("r31 sum b", sum1, 4);
        cyc(0, 0, 0, 1);

        // Random traffic checked by the model
        for (int k = 0; k < 4000; k++) begin
            cyc(($urandom_range(0, 31) == 0),
                ($urandom_range(0, 9) < 7),
                int'($urandom_range(0, 15)),
                ($urandom_range(0, 9) < 6));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
